// File: rtl/agc_error_accum_mc_if.sv
// Sample-stream and error-output bundle for the multi-channel AGC
// error accumulator.
interface agc_error_accum_mc_if #(
   parameter int BWIDTH   = 18,
   parameter int AWIDTH   = 30,
   parameter int DWIDTH   = 27,
   parameter int OUTWIDTH = 48,
   parameter int CH_W     = 2
);
   logic                       Valid;
   logic [CH_W-1:0]            Channel;
   logic signed [AWIDTH-1:0]   Port_Data_A;
   logic [DWIDTH-1:0]          R_level;
   logic [BWIDTH-1:0]          Error_Coefficient;
   logic                       Accum_Clear;
   logic                       Valid_out_error;
   logic [CH_W-1:0]            Channel_out;
   logic signed [OUTWIDTH-1:0] Error_Out;
   logic                       Sat_out;

   modport master (
      output Valid, Channel, Port_Data_A,
      output R_level, Error_Coefficient,
      output Accum_Clear,
      input  Valid_out_error, Channel_out,
      input  Error_Out, Sat_out
   );

   modport slave (
      input  Valid, Channel, Port_Data_A,
      input  R_level, Error_Coefficient,
      input  Accum_Clear,
      output Valid_out_error, Channel_out,
      output Error_Out, Sat_out
   );
endinterface

// File: rtl/agc_error_accum_mc.sv
// Multi-channel AGC error accumulator: acc[ch] += Coeff*(R-Data), saturating.
// Define AGC_ERR_LEAK_EN to turn the integrator into a leaky one.
module agc_error_accum_mc #(
   parameter int BWIDTH     = 18,
   parameter int AWIDTH     = 30,
   parameter int DWIDTH     = 27,
   parameter int OUTWIDTH   = 48,
   parameter int NUM_CH     = 4,
   parameter int CH_W       = 2,
   parameter int LEAK_SHIFT = 12
) (
   input logic                 clk,
   input logic                 rst,
   agc_error_accum_mc_if.slave bus
);
   localparam int DIFFW =
      (AWIDTH > DWIDTH + 1 ? AWIDTH : DWIDTH + 1) + 1;
   localparam int PW = BWIDTH + 1 + DIFFW;
   localparam int SW = (OUTWIDTH > PW ? OUTWIDTH : PW) + 1;

   localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);

   localparam logic signed [SW-1:0] MAXV =
      {{(SW - OUTWIDTH + 1){1'b0}}, {(OUTWIDTH - 1){1'b1}}};
   localparam logic signed [SW-1:0] MINV =
      {{(SW - OUTWIDTH + 1){1'b1}}, {(OUTWIDTH - 1){1'b0}}};

   logic                       v1, v2, v3, v4;
   logic [CH_W-1:0]            ch1, ch2, ch3, ch4;
   logic signed [AWIDTH-1:0]   d1;
   logic [DWIDTH-1:0]          r1;
   logic [BWIDTH-1:0]          c1, c2;
   logic signed [DIFFW-1:0]    diff2;
   logic signed [PW-1:0]       prod3, prod4;

   logic signed [OUTWIDTH-1:0] acc [NUM_CH];

   logic signed [OUTWIDTH-1:0] acc_rd;
   logic signed [OUTWIDTH-1:0] base;
   logic signed [SW-1:0]       sum;
   logic signed [OUTWIDTH-1:0] res;
   logic                       sat;

   logic                       vo;
   logic [CH_W-1:0]            cho;
   logic signed [OUTWIDTH-1:0] eo;
   logic                       so;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         v4 <= 1'b0;
      end else begin
         v1 <= bus.Valid && ({1'b0, bus.Channel} < NCH);
         v2 <= v1;
         v3 <= v2;
         v4 <= v3;
      end
   end

   // prod4 re-registers the product so the multiply maps onto a
   // DSP with both pipeline registers enabled.
   always_ff @(posedge clk) begin
      ch1   <= bus.Channel;
      d1    <= bus.Port_Data_A;
      r1    <= bus.R_level;
      c1    <= bus.Error_Coefficient;
      ch2   <= ch1;
      c2    <= c1;
      diff2 <= $signed({{(DIFFW - DWIDTH){1'b0}}, r1})
             - $signed({{(DIFFW - AWIDTH){d1[AWIDTH-1]}}, d1});
      ch3   <= ch2;
      prod3 <= $signed({{(PW - BWIDTH){1'b0}}, c2})
             * $signed({{(PW - DIFFW){diff2[DIFFW-1]}}, diff2});
      ch4   <= ch3;
      prod4 <= prod3;
   end

   always_comb begin
      acc_rd = bus.Accum_Clear ? '0 : acc[ch4];
`ifdef AGC_ERR_LEAK_EN
      base = acc_rd - (acc_rd >>> LEAK_SHIFT);
`else
      base = acc_rd;
`endif
      sum = $signed({{(SW - OUTWIDTH){base[OUTWIDTH-1]}}, base})
          + $signed({{(SW - PW){prod4[PW-1]}}, prod4});
      res = sum[OUTWIDTH-1:0];
      sat = 1'b0;
      if (sum > MAXV) begin
         res = MAXV[OUTWIDTH-1:0];
         sat = 1'b1;
      end else if (sum < MINV) begin
         res = MINV[OUTWIDTH-1:0];
         sat = 1'b1;
      end
   end

`ifndef AGC_ERR_LEAK_EN
   logic [31:0] unused_leak;
   assign unused_leak = 32'(LEAK_SHIFT);
`endif

   // Clear first, then the S4 write, so a colliding sample lands on zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else begin
         if (bus.Accum_Clear)
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
         if (v4) acc[ch4] <= res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vo  <= 1'b0;
         cho <= '0;
         eo  <= '0;
         so  <= 1'b0;
      end else begin
         vo <= v4;
         if (v4) begin
            cho <= ch4;
            eo  <= res;
            so  <= sat;
         end
      end
   end

   assign bus.Valid_out_error = vo;
   assign bus.Channel_out     = cho;
   assign bus.Error_Out       = eo;
   assign bus.Sat_out         = so;
endmodule
